swm_tx_adapter: RTL

//  Transmit-side adapter for the SerialLite III streaming link.
//  - Converts a 32-bit Avalon-ST packet sink into the 64-bit SL3 TX user interface. One word becomes one beat; SOP/EOP map to start/end of burst.
//  - Enforces packet framing and registers all outputs through a 2-entry skid buffer.
//  - Sits between the local stream producer and the SL3 IP TX port, mirroring the RX adapter on the far end.

---
 rtl/swm_pkg.sv | 25 ++
 rtl/swm_skid_buf.sv | 72 +++++++
 rtl/swm_tx_adapter.sv | 116 +++++++++++
 3 files changed

// File: rtl/swm_pkg.sv
// ------------------------------------------------------------------
// swm_pkg: shared types for the SerialLite III stream adapters. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package swm_pkg;

  localparam int SWM_TAG_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } swm_fsm_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sob;
    logic        eob;
  } swm_beat_t;

  localparam int SWM_BEAT_W = $bits(swm_beat_t);

endpackage

`default_nettype wire

// File: rtl/swm_skid_buf.sv
// ------------------------------------------------------------------
// swm_skid_buf: 2-entry registered ready/valid buffer. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module swm_skid_buf #(
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_valid_d, skid_valid_d;
  logic [WIDTH-1:0] main_data_d, skid_data_d;
  logic             push, drain;

  assign push  = in_valid & in_ready;
  assign drain = main_valid & out_ready;

  // in_ready is registered, so a push can only land while the skid slot is empty.
  always_comb begin
    main_valid_d = main_valid;
    main_data_d  = main_data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (drain || !main_valid) begin
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data;
        skid_valid_d = push;
        if (push) skid_data_d = in_data;
      end else begin
        main_valid_d = push;
        if (push) main_data_d = in_data;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      main_data  <= main_data_d;
      skid_data  <= skid_data_d;
      in_ready   <= !skid_valid_d && enable;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

`default_nettype wire

// File: rtl/swm_tx_adapter.sv
// ------------------------------------------------------------------
// swm_tx_adapter: Avalon-ST 32-bit sink to SL3 64-bit TX adapter. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module swm_tx_adapter
  import swm_pkg::*;
#(
  parameter logic [7:0] SYNC_VALUE = 8'h00,
  parameter bit          TAG_ENABLE = 1'b1,
  parameter int          ERR_CNT_W  = 16
) (
  input  logic                 clk_in_clk,
  input  logic                 reset_in_rst_n,
  input  logic [31:0]          avalonst_sink_data,
  input  logic                 avalonst_sink_valid,
  input  logic                 avalonst_sink_startofpacket,
  input  logic                 avalonst_sink_endofpacket,
  output logic                 avalonst_sink_ready,
  output logic [63:0]          data_tx,
  output logic                 valid_tx,
  output logic                 start_of_burst_tx,
  output logic                 end_of_burst_tx,
  output logic [7:0]           sync_tx,
  input  logic                 ready_tx,
  input  logic                 link_up_tx,
  output logic [ERR_CNT_W-1:0] frame_err_count
);

  swm_fsm_t               state, state_d;
  logic [SWM_TAG_W-1:0]   next_id, cur_id, word_idx;
  logic [SWM_TAG_W-1:0]   tag_id, tag_idx;
  logic [ERR_CNT_W-1:0]   err_cnt;
  logic                   accept, fwd, sob, frame_err;
  logic                   buf_in_ready, buf_out_valid;
  swm_beat_t              in_beat, out_beat;

  assign accept = avalonst_sink_valid & buf_in_ready;

  // Orphan beats are accepted (fwd = 0) but never pushed into the buffer.
  always_comb begin
    fwd       = 1'b0;
    sob       = 1'b0;
    frame_err = 1'b0;
    state_d   = state;
    tag_id    = cur_id;
    tag_idx   = word_idx;
    if (accept) begin
      if (avalonst_sink_startofpacket) begin
        fwd       = 1'b1;
        sob       = 1'b1;
        tag_id    = next_id;
        tag_idx   = '0;
        frame_err = (state == IN_PKT);
        state_d   = avalonst_sink_endofpacket ? IDLE : IN_PKT;
      end else if (state == IN_PKT) begin
        fwd     = 1'b1;
        state_d = avalonst_sink_endofpacket ? IDLE : IN_PKT;
      end else begin
        frame_err = 1'b1;
      end
    end
  end

  always_comb begin
    in_beat.data = {(TAG_ENABLE ? {tag_id, tag_idx} : 32'h0), avalonst_sink_data};
    in_beat.sob  = sob;
    in_beat.eob  = avalonst_sink_endofpacket;
  end

  always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
    if (!reset_in_rst_n) begin
      state    <= IDLE;
      next_id  <= '0;
      cur_id   <= '0;
      word_idx <= '0;
      err_cnt  <= '0;
    end else begin
      state <= state_d;
      if (fwd) begin
        word_idx <= tag_idx + 16'd1;
        if (sob) begin
          cur_id  <= next_id;
          next_id <= next_id + 16'd1;
        end
      end
      if (frame_err && (err_cnt != {ERR_CNT_W{1'b1}}))
        err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  swm_skid_buf #(
    .WIDTH (SWM_BEAT_W)
  ) u_skid (
    .clk       (clk_in_clk),
    .rst_n     (reset_in_rst_n),
    .enable    (link_up_tx),
    .in_data   (in_beat),
    .in_valid  (fwd),
    .in_ready  (buf_in_ready),
    .out_data  (out_beat),
    .out_valid (buf_out_valid),
    .out_ready (ready_tx)
  );

  assign avalonst_sink_ready = buf_in_ready;
  assign data_tx             = out_beat.data;
  assign valid_tx            = buf_out_valid;
  assign start_of_burst_tx   = buf_out_valid & out_beat.sob;
  assign end_of_burst_tx     = buf_out_valid & out_beat.eob;
  assign sync_tx             = SYNC_VALUE;
  assign frame_err_count     = err_cnt;

endmodule

`default_nettype wire
